// File: rtl/uart_rx.sv
// UART receive engine: 2-flop synchronised input, falling-edge frame detection,
// mid-bit sampling of start, 8 data bits (LSB first) and stop bit.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_busy
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned HALF         = BAUD_CNT_MAX / 2;

  localparam logic [15:0] CNT_LAST = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] CNT_HALF = 16'(HALF);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic        rx_s1_q, rx_s2_q, rx_d_q;
  state_e      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;

  logic fall_edge;
  logic sample_pt;
  logic wrap_pt;

  assign fall_edge = rx_d_q & ~rx_s2_q;
  assign sample_pt = (baud_cnt_q == CNT_HALF);
  assign wrap_pt   = (baud_cnt_q == CNT_LAST);

  // Synchronise the asynchronous line and keep one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      rx_s1_q <= uart_rxd;
      rx_s2_q <= rx_s1_q;
      rx_d_q  <= rx_s2_q;
    end
  end

  // Register the receiver state, counters, shift register and output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state logic: bit timing, sampling and frame completion.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;

    if (state_q != IDLE) begin
      baud_cnt_d = wrap_pt ? '0 : baud_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d    = START;
          baud_cnt_d = '0;
        end
      end
      START: begin
        if (sample_pt && rx_s2_q) begin
          // Line went back high before mid-bit: treat as a glitch.
          state_d    = IDLE;
          baud_cnt_d = '0;
        end else if (wrap_pt) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (sample_pt) begin
          shift_d = {rx_s2_q, shift_q[7:1]};
        end
        if (wrap_pt) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Leave at mid stop bit so a following start edge is not missed.
        if (sample_pt) begin
          state_d    = IDLE;
          baud_cnt_d = '0;
          if (rx_s2_q) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_done      = done_q;
  assign uart_rx_frame_err = ferr_q;
  assign uart_rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 10 clocks per bit (CLK_FREQ=1000, UART_BPS=100).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rxd;
  logic [7:0] uart_rx_data;
  logic       uart_rx_done;
  logic       uart_rx_frame_err;
  logic       uart_rx_busy;

  uart_rx #(
    .CLK_FREQ(1000),
    .UART_BPS(100)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .uart_rxd         (uart_rxd),
    .uart_rx_data     (uart_rx_data),
    .uart_rx_done     (uart_rx_done),
    .uart_rx_frame_err(uart_rx_frame_err),
    .uart_rx_busy     (uart_rx_busy)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [7:0]  data;
    int unsigned cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  int unsigned busy_cnt = 0;
  int unsigned rise_cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned both_cnt = 0;
  logic        busy_prev = 1'b0;

  logic [7:0] last_good = 8'h00;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (uart_rx_done) obs_q.push_back('{err: 1'b0, data: uart_rx_data, cyc: cyc});
    if (uart_rx_frame_err) obs_q.push_back('{err: 1'b1, data: uart_rx_data, cyc: cyc});
    if (uart_rx_done && uart_rx_frame_err) both_cnt++;
    if (uart_rx_busy) busy_cnt++;
    if (uart_rx_busy && !busy_prev) rise_cyc = cyc;
    if (!uart_rx_busy && busy_prev) fall_cyc = cyc;
    busy_prev = uart_rx_busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    uart_rxd = 1'b1;
    wait_cycles(n);
  endtask

  task automatic drive_bit(input logic b);
    uart_rxd = b;
    wait_cycles(10);
  endtask

  // Reference: the line falls after edge c, so the detection edge is c+3 and the
  // stop bit (bit 9) is sampled on c+3+96; the strobe is seen right after it.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    int unsigned c;
    c = cyc;
    exp_q.push_back('{err: !stop_ok, data: (stop_ok ? b : last_good), cyc: c + 99});
    if (stop_ok) last_good = b;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic check_events(input string tag);
    int unsigned n;
    chk({tag, ".count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < int'(n); i++) begin
      chk({tag, ".kind"}, 32'(obs_q[i].err), 32'(exp_q[i].err));
      chk({tag, ".data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
      chk({tag, ".cyc"}, obs_q[i].cyc, exp_q[i].cyc);
    end
    chk({tag, ".held_data"}, 32'(uart_rx_data), 32'(last_good));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int unsigned c;
    logic [7:0]  b;

    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    wait_cycles(3);
    chk("rst.data", 32'(uart_rx_data), 32'h00);
    chk("rst.done", 32'(uart_rx_done), 32'h0);
    chk("rst.ferr", 32'(uart_rx_frame_err), 32'h0);
    chk("rst.busy", 32'(uart_rx_busy), 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Single good frame 0x55.
    busy_cnt = 0;
    send_frame(8'h55, 1'b1);
    idle(10);
    chk("f55.busy_cycles", busy_cnt, 32'd96);
    check_events("f55");

    // Three-cycle low glitch on an idle line.
    busy_cnt = 0;
    c = cyc;
    uart_rxd = 1'b0;
    wait_cycles(3);
    idle(20);
    chk("glitch.rise", rise_cyc, c + 3);
    chk("glitch.fall", fall_cyc, c + 9);
    chk("glitch.busy_cycles", busy_cnt, 32'd6);
    check_events("glitch");

    // Good 0x3C followed by 0xA5 with a low stop bit.
    send_frame(8'h3C, 1'b1);
    idle(4);
    send_frame(8'hA5, 1'b0);
    idle(20);
    check_events("ferr");

    // Back-to-back frames with no idle gap.
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(10);
    check_events("b2b");

    // Reset asserted in the middle of data bit 4.
    b = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    uart_rxd = b[3];
    wait_cycles(5);
    rst_n = 1'b0;
    #1;
    chk("midrst.data", 32'(uart_rx_data), 32'h00);
    chk("midrst.done", 32'(uart_rx_done), 32'h0);
    chk("midrst.ferr", 32'(uart_rx_frame_err), 32'h0);
    chk("midrst.busy", 32'(uart_rx_busy), 32'h0);
    last_good = 8'h00;
    uart_rxd = 1'b1;
    wait_cycles(5);
    rst_n = 1'b1;
    idle(10);
    check_events("midrst");
    send_frame(8'h81, 1'b1);
    idle(10);
    check_events("after_rst");

    // Break: line low for 30 bit periods gives exactly one framing error.
    c = cyc;
    exp_q.push_back('{err: 1'b1, data: last_good, cyc: c + 99});
    uart_rxd = 1'b0;
    wait_cycles(300);
    idle(20);
    check_events("break");
    send_frame(8'h0F, 1'b1);
    idle(10);
    check_events("after_break");

    // Random frames with random idle gaps and occasional bad stop bits.
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(2, 12));
      send_frame(8'($urandom), ($urandom_range(0, 4) != 0));
    end
    idle(10);
    check_events("rand");

    chk("done_ferr_exclusive", both_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
